// File: rtl/sync_mem_responder_if.sv
// sync_mem_responder_if: request/response bus between a datapath and the synchronous memory responder.
interface sync_mem_responder_if;
    logic        MOV;
    logic        RW;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [5:0]  OpC;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Err;
    modport master (output MOV, RW, Address, DataIn, OpC, input DataOut, MOC, Err);
    modport slave  (input MOV, RW, Address, DataIn, OpC, output DataOut, MOC, Err);
endinterface

// File: rtl/sync_mem_responder.sv
// sync_mem_responder: 512-byte big-endian memory answering MOV/MOC four-phase requests after WAIT_CYCLES.
module sync_mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    sync_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [7:0] Mem [0:511];
    logic [3:0] cnt;
    logic rw_q;
    logic [8:0] addr_q;
    logic [5:0] opc_q;
    logic [31:0] din_q, dout;
    logic err;
    logic cap, acc, rw, bad, sgn;
    logic [8:0] a;
    logic [5:0] opc;
    logic [31:0] din, rd;
    logic [1:0] sz;
    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        state_n = state;
        cap = 1'b0;
        acc = 1'b0;
        case (state)
            IDLE: if (bus.MOV) begin
                cap = 1'b1;
                acc = (WAIT_CYCLES == 0);
                state_n = acc ? DONE : BUSY;
            end
            BUSY: if (cnt <= 4'd1) begin
                acc = 1'b1;
                state_n = DONE;
            end
            DONE: if (!bus.MOV) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // A zero-wait access uses the live inputs on the capture edge; otherwise the latched copy.
    assign a   = cap ? bus.Address : addr_q;
    assign rw  = cap ? bus.RW : rw_q;
    assign opc = cap ? bus.OpC : opc_q;
    assign din = cap ? bus.DataIn : din_q;
    assign sz  = opc[1:0];
    assign sgn = !opc[2];
    assign bad = !(opc inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                               6'b101000, 6'b101001, 6'b101011})
                 || (sz == 2'b01 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
    assign b0 = Mem[a];
    assign b1 = Mem[a + 9'd1];
    assign b2 = Mem[a + 9'd2];
    assign b3 = Mem[a + 9'd3];
    assign rd = sz == 2'b00 ? {{24{sgn & b0[7]}}, b0} :
                sz == 2'b01 ? {{16{sgn & b0[7]}}, b0, b1} : {b0, b1, b2, b3};
    // Mem is deliberately left out of the reset branch so its contents survive reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rw_q   <= 1'b0;
            addr_q <= 9'd0;
            opc_q  <= 6'd0;
            din_q  <= 32'd0;
            dout   <= 32'd0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            if (cap) begin
                rw_q   <= bus.RW;
                addr_q <= bus.Address;
                opc_q  <= bus.OpC;
                din_q  <= bus.DataIn;
                cnt    <= 4'(WAIT_CYCLES);
                err    <= 1'b0;
            end else if (state == BUSY) cnt <= cnt - 4'd1;
            if (acc) begin
                err <= bad;
                if (rw) dout <= bad ? 32'd0 : rd;
                else if (!bad) begin
                    Mem[a] <= sz == 2'b00 ? din[7:0] : sz == 2'b01 ? din[15:8] : din[31:24];
                    if (sz != 2'b00) Mem[a + 9'd1] <= sz == 2'b01 ? din[7:0] : din[23:16];
                    if (sz == 2'b11) begin
                        Mem[a + 9'd2] <= din[15:8];
                        Mem[a + 9'd3] <= din[7:0];
                    end
                end
            end
        end
    end
    assign bus.MOC     = (state == DONE);
    assign bus.DataOut = dout;
    assign bus.Err     = err;
endmodule

// File: tb/tb_sync_mem_responder.sv
// tb_sync_mem_responder: directed vector table, corner sequences and random traffic against a byte-array model.
module tb_sync_mem_responder;
    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100,
                           LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
    typedef struct {
        logic rw;
        logic [5:0] opc;
        logic [8:0] a;
        logic [31:0] d;
        logic [31:0] dout;
        logic err;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [7:0] mem_m [512];
    logic [31:0] m_dout = 32'd0;
    vec_t tbl [15];
    logic [5:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    always #5 clk = ~clk;
    sync_mem_responder_if bus2 ();
    sync_mem_responder_if bus0 ();
    sync_mem_responder #(.WAIT_CYCLES(2)) u2 (.clk(clk), .reset(rst), .bus(bus2.slave));
    sync_mem_responder #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst), .bus(bus0.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int size_of(input logic [5:0] opc);
        return (opc == LB || opc == LBU || opc == SB) ? 1 :
               (opc == LH || opc == LHU || opc == SH) ? 2 : (opc == LW || opc == SW) ? 4 : 0;
    endfunction

    // Reference: big-endian byte array, size/sign from the opcode, errors on misalignment.
    task automatic model(input logic rw, input logic [5:0] opc, input logic [8:0] a, input logic [31:0] d,
                         output logic [31:0] dout, output logic err);
        int sz = size_of(opc);
        logic [31:0] v = 32'd0;
        err = (sz == 0) ? 1'b1 : ((int'(a) % sz) != 0);
        if (rw) begin
            if (!err) begin
                for (int i = 0; i < sz; i++) v = (v << 8) | 32'(mem_m[(int'(a) + i) % 512]);
                if ((opc == LB || opc == LH) && v[8 * sz - 1]) v = v | (32'hFFFFFFFF << (8 * sz));
            end
            m_dout = v;
        end else if (!err)
            for (int i = 0; i < sz; i++) mem_m[(int'(a) + i) % 512] = 8'(d >> (8 * (sz - 1 - i)));
        dout = m_dout;
    endtask

    function automatic logic [31:0] word2(input logic [8:0] a);
        return {u2.Mem[a], u2.Mem[a + 9'd1], u2.Mem[a + 9'd2], u2.Mem[a + 9'd3]};
    endfunction

    function automatic logic [31:0] mword(input logic [8:0] a);
        return {mem_m[a], mem_m[a + 9'd1], mem_m[a + 9'd2], mem_m[a + 9'd3]};
    endfunction

    task automatic drive(input bit z, input logic mov, input logic rw, input logic [5:0] opc,
                         input logic [8:0] a, input logic [31:0] d);
        if (z) begin
            bus0.MOV = mov; bus0.RW = rw; bus0.OpC = opc; bus0.Address = a; bus0.DataIn = d;
        end else begin
            bus2.MOV = mov; bus2.RW = rw; bus2.OpC = opc; bus2.Address = a; bus2.DataIn = d;
        end
    endtask

    function automatic logic moc_of(input bit z);
        return z ? bus0.MOC : bus2.MOC;
    endfunction

    // One request: scramble inputs after capture, check latency/result, optional MOV hold, then MOC fall.
    task automatic txn(input bit z, input logic rw, input logic [5:0] opc, input logic [8:0] a,
                       input logic [31:0] d, input int hold, input bit drop, input bit use_model,
                       input logic [31:0] xd_in, input logic xe_in, input string nm);
        int n = 0;
        logic [31:0] md, xd;
        logic me, xe;
        logic [8:0] ha = 9'($urandom) & 9'h1FC;
        xd = xd_in;
        xe = xe_in;
        if (!z) begin
            model(rw, opc, a, d, md, me);
            if (use_model) begin
                xd = md;
                xe = me;
            end
        end
        @(negedge clk);
        drive(z, 1'b1, rw, opc, a, d);
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) drive(z, !drop, 1'($urandom), 6'($urandom), 9'($urandom), $urandom);
        end while (!moc_of(z) && n < 20);
        chk({nm, " latency"}, 32'(n), z ? 32'd1 : 32'd3);
        chk({nm, " dataout"}, z ? bus0.DataOut : bus2.DataOut, xd);
        chk({nm, " err"}, 32'(z ? bus0.Err : bus2.Err), 32'(xe));
        for (int i = 0; i < hold; i++) begin
            drive(z, 1'b1, 1'b0, SW, ha, $urandom);
            @(posedge clk);
            #1;
            chk({nm, " moc_hold"}, 32'(moc_of(z)), 32'd1);
        end
        drive(z, 1'b0, 1'b0, SW, ha, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, " moc_fall"}, 32'(moc_of(z)), 32'd0);
        if (hold > 0) chk({nm, " no_second_access"}, word2(ha), mword(ha));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        logic [5:0] opc;
        logic [8:0] a;
        logic rw;
        int hold;
        bit drop;
        tbl[0]  = '{1'b1, LW,  9'd0,   32'd0,         32'h8C010004, 1'b0};
        tbl[1]  = '{1'b1, LB,  9'd0,   32'd0,         32'hFFFFFF8C, 1'b0};
        tbl[2]  = '{1'b1, LBU, 9'd0,   32'd0,         32'h0000008C, 1'b0};
        tbl[3]  = '{1'b1, LH,  9'd2,   32'd0,         32'h00000004, 1'b0};
        tbl[4]  = '{1'b1, LHU, 9'd0,   32'd0,         32'h00008C01, 1'b0};
        tbl[5]  = '{1'b0, SW,  9'd8,   32'hDEADBEEF,  32'h00008C01, 1'b0};
        tbl[6]  = '{1'b0, SB,  9'd9,   32'h000000AA,  32'h00008C01, 1'b0};
        tbl[7]  = '{1'b1, LW,  9'd8,   32'd0,         32'hDEAABEEF, 1'b0};
        tbl[8]  = '{1'b0, SH,  9'd10,  32'h00001234,  32'hDEAABEEF, 1'b0};
        tbl[9]  = '{1'b1, LW,  9'd8,   32'd0,         32'hDEAA1234, 1'b0};
        tbl[10] = '{1'b1, LW,  9'd2,   32'd0,         32'h00000000, 1'b1};
        tbl[11] = '{1'b0, SH,  9'd5,   32'h0000BEEF,  32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 6'b000000, 9'd0, 32'd0,     32'h00000000, 1'b1};
        tbl[13] = '{1'b0, SW,  9'd508, 32'h11223344,  32'h00000000, 1'b0};
        tbl[14] = '{1'b1, LW,  9'd508, 32'd0,         32'h11223344, 1'b0};
        drive(0, 1'b0, 1'b1, LW, 9'd0, 32'd0);
        drive(1, 1'b0, 1'b1, LW, 9'd0, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("reset moc", 32'(bus2.MOC), 32'd0);
        chk("reset err", 32'(bus2.Err), 32'd0);
        chk("reset dataout", bus2.DataOut, 32'd0);
        chk("reset moc w0", 32'(bus0.MOC), 32'd0);
        for (int i = 0; i < 512; i++) begin
            v = 8'($urandom);
            u2.Mem[i] = v;
            mem_m[i] = v;
        end
        u2.Mem[0] = 8'h8C; u2.Mem[1] = 8'h01; u2.Mem[2] = 8'h00; u2.Mem[3] = 8'h04;
        mem_m[0] = 8'h8C; mem_m[1] = 8'h01; mem_m[2] = 8'h00; mem_m[3] = 8'h04;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            txn(0, tbl[i].rw, tbl[i].opc, tbl[i].a, tbl[i].d, 0, 0, 0, tbl[i].dout, tbl[i].err,
                $sformatf("vec%0d", i));
            if (i == 11) chk("sh5 mem unchanged", word2(9'd4), mword(9'd4));
        end
        chk("mem 508..511", word2(9'd508), 32'h11223344);
        txn(0, 1'b1, LW, 9'd0, 32'd0, 3, 0, 1, 32'd0, 1'b0, "hold_mov");
        txn(0, 1'b1, LB, 9'd1, 32'd0, 0, 1, 1, 32'd0, 1'b0, "drop_in_busy");
        @(negedge clk);
        drive(0, 1'b1, 1'b0, SW, 9'd508, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("busy reset moc", 32'(bus2.MOC), 32'd0);
        chk("busy reset err", 32'(bus2.Err), 32'd0);
        chk("busy reset dataout", bus2.DataOut, 32'd0);
        drive(0, 1'b0, 1'b0, SW, 9'd508, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_dout = 32'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy reset no write", word2(9'd508), 32'h11223344);
        txn(1, 1'b0, SW, 9'd16, 32'h55667788, 0, 0, 0, 32'd0, 1'b0, "w0 sw");
        txn(1, 1'b1, LW, 9'd16, 32'd0, 0, 0, 0, 32'h55667788, 1'b0, "w0 lw");
        txn(1, 1'b1, LB, 9'd17, 32'd0, 0, 0, 0, 32'h00000066, 1'b0, "w0 lb");
        txn(1, 1'b1, LH, 9'd17, 32'd0, 0, 0, 0, 32'h00000000, 1'b1, "w0 lh misaligned");
        for (int k = 0; k < 60; k++) begin
            int sel = $urandom_range(0, 8);
            if (sel < 8) begin
                opc = ops[sel];
                rw = !opc[3];
            end else begin
                opc = {1'b0, 5'($urandom)};
                rw = 1'($urandom);
            end
            a = $urandom_range(0, 1) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(480, 511));
            if ($urandom_range(0, 3) != 0 && size_of(opc) > 1) a = a & ~9'(size_of(opc) - 1);
            drop = ($urandom_range(0, 3) == 0);
            hold = drop ? 0 : $urandom_range(0, 2);
            txn(0, rw, opc, a, $urandom, hold, drop, 1, 32'd0, 1'b0, $sformatf("rand%0d", k));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
